// File: rtl/pram_phase_sequencer.sv
// Three-phase sine LUT sequencer: steps the PRAM address at a programmable rate and
// registers the returned samples. Define PHASE_DIR_EN to add a dir input for reverse stepping.

module pram_lane_cap #(
  parameter int DATA_W = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cap,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)   q <= '0;
    else if (cap) q <= d;
endmodule

module pram_phase_sequencer #(
  parameter int ADDR_W   = 12,
  parameter int SIN_SIZE = 3000,
  parameter int DIV_W    = 16,
  parameter int DATA_W   = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
`ifdef PHASE_DIR_EN
  input  logic              dir,
`endif
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic [ADDR_W-1:0] pram_addr,
  input  logic [DATA_W-1:0] pram_a,
  input  logic [DATA_W-1:0] pram_b,
  input  logic [DATA_W-1:0] pram_c,
  output logic [DATA_W-1:0] sample_a,
  output logic [DATA_W-1:0] sample_b,
  output logic [DATA_W-1:0] sample_c,
  output logic              sample_valid,
  output logic              period_start,
  output logic              running
);
  localparam int NUM_LANES = 3;
  localparam int STAGES    = 1;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(SIN_SIZE - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  typedef struct packed {
    logic             vld;
    logic [DIV_W-1:0] div;
  } cfg_t;

  state_t                          state, state_nxt;
  logic [DIV_W-1:0]                cnt, active_div;
  cfg_t                            pend;
  logic                            applied_q;
  logic                            tick, wrap, start, xfer;
  logic [ADDR_W-1:0]               addr_nxt;
  logic [STAGES:0]                 vld_pipe;
  logic [NUM_LANES-1:0][DATA_W-1:0] lut_d, smp_q;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (enable) state_nxt = RUN;
      RUN:     if (!enable) state_nxt = DRAIN;
      DRAIN:   if (enable) state_nxt = RUN;
               else if (wrap) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    running = 1'b0;
    unique case (state)
      RUN, DRAIN: running = 1'b1;
      default:    running = 1'b0;
    endcase
  end

  // ---------------- step timing ----------------
  assign tick  = running && (cnt == active_div - DIV_W'(1));
  assign start = (state == IDLE) && enable;

`ifdef PHASE_DIR_EN
  always_comb begin
    if (dir) addr_nxt = (pram_addr == '0)   ? LAST : pram_addr - ADDR_W'(1);
    else     addr_nxt = (pram_addr == LAST) ? '0   : pram_addr + ADDR_W'(1);
  end
`else
  assign addr_nxt = (pram_addr == LAST) ? '0 : pram_addr + ADDR_W'(1);
`endif

  // A period boundary is any step that lands on address 0, in either direction.
  assign wrap = tick && (addr_nxt == '0);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt       <= '0;
      pram_addr <= '0;
    end else if (!running) begin
      cnt       <= '0;
      pram_addr <= '0;
    end else if (tick) begin
      cnt       <= '0;
      pram_addr <= addr_nxt;
    end else begin
      cnt       <= cnt + DIV_W'(1);
    end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) period_start <= 1'b0;
    else        period_start <= wrap;

  // ---------------- divider handshake ----------------
  assign xfer = cfg_valid && cfg_ready;

  // Running: the new divider lands on the wrap step so the next period is clean;
  // ready reopens one cycle later so a fresh offer cannot collide with the apply.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      active_div <= DIV_W'(1);
      pend       <= '0;
      cfg_ready  <= 1'b1;
      applied_q  <= 1'b0;
    end else begin
      applied_q <= 1'b0;
      if (xfer) begin
        pend.vld  <= 1'b1;
        pend.div  <= cfg_div;
        cfg_ready <= 1'b0;
      end else if (pend.vld && (!running || wrap)) begin
        active_div <= (pend.div == '0) ? DIV_W'(1) : pend.div;
        pend.vld   <= 1'b0;
        if (running) applied_q <= 1'b1;
        else         cfg_ready <= 1'b1;
      end else if (applied_q) begin
        cfg_ready <= 1'b1;
      end
    end

  // ---------------- sample capture ----------------
  // vld_pipe[0]: address just changed, PRAM output settling; vld_pipe[1]: sample registered.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) vld_pipe <= '0;
    else        vld_pipe <= {vld_pipe[STAGES-1:0], tick | start};

  assign lut_d        = {pram_c, pram_b, pram_a};
  assign sample_valid = vld_pipe[STAGES];

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    pram_lane_cap #(.DATA_W(DATA_W)) u_cap (
      .clk   (clk),
      .rst_n (rst_n),
      .cap   (vld_pipe[0]),
      .d     (lut_d[i]),
      .q     (smp_q[i])
    );
  end

  assign sample_a = smp_q[0];
  assign sample_b = smp_q[1];
  assign sample_c = smp_q[2];

endmodule

// File: tb/tb_pram_phase_sequencer.sv
// Bench for pram_phase_sequencer: per-cycle scoreboard against an event-scheduled model,
// a divider table, and directed sequences for wrap/config/drain/reset corners.

module tb_pram_phase_sequencer;
  localparam int ADDR_W = 12, SIN = 3000, DIV_W = 16, DATA_W = 7;

  logic              clk = 1'b0, rst_n = 1'b0, enable = 1'b0, cfg_valid = 1'b0;
  logic [DIV_W-1:0]  cfg_div = '0;
  logic              cfg_ready, sample_valid, period_start, running;
  logic [ADDR_W-1:0] pram_addr;
  logic [DATA_W-1:0] pram_a, pram_b, pram_c, sample_a, sample_b, sample_c;
`ifdef PHASE_DIR_EN
  logic              dir = 1'b0;
`endif

  int errors = 0, checks = 0, fail_prints = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] lut(input int lane, input int a);
    case (lane)
      0:       return DATA_W'((a * 7 + 3) % 128);
      1:       return DATA_W'((a * 13 + 50) % 128);
      default: return DATA_W'(((a / 3) ^ a) % 128);
    endcase
  endfunction

  assign pram_a = lut(0, int'(pram_addr));
  assign pram_b = lut(1, int'(pram_addr));
  assign pram_c = lut(2, int'(pram_addr));

  pram_phase_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
`ifdef PHASE_DIR_EN
    .dir          (dir),
`endif
    .cfg_div      (cfg_div),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .pram_addr    (pram_addr),
    .pram_a       (pram_a),
    .pram_b       (pram_b),
    .pram_c       (pram_c),
    .sample_a     (sample_a),
    .sample_b     (sample_b),
    .sample_c     (sample_c),
    .sample_valid (sample_valid),
    .period_start (period_start),
    .running      (running)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (fail_prints < 40) begin
        fail_prints++;
        $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
    end
  endtask

  // Reference model: the step schedule is kept as the absolute edge number of the next
  // address change (start/step edge + divider), not as a running counter.
  int m_st = 0, m_addr = 0, m_div = 1, m_next = 0, m_edge = 0, m_ready_at = -1, m_pdiv = 0;
  bit m_ready = 1'b1, m_pv = 1'b0, m_upd = 1'b0, m_sv = 1'b0, m_ps = 1'b0;
  logic [DATA_W-1:0] m_sa = '0, m_sb = '0, m_sc = '0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_st = 0; m_addr = 0; m_div = 1; m_next = 0; m_edge = 0; m_ready_at = -1;
      m_ready = 1'b1; m_pv = 1'b0; m_upd = 1'b0; m_sv = 1'b0; m_ps = 1'b0;
      m_sa = '0; m_sb = '0; m_sc = '0;
    end else begin
      bit step, wrp, strt;
      m_edge++;
      step = (m_st != 0) && (m_edge == m_next);
      wrp  = step && (m_addr == SIN - 1);
      strt = (m_st == 0) && enable;
      m_sv = m_upd;
      if (m_upd) begin
        m_sa = lut(0, m_addr); m_sb = lut(1, m_addr); m_sc = lut(2, m_addr);
      end
      m_upd = step || strt;
      m_ps  = wrp;
      if (m_ready && cfg_valid) begin
        m_pv = 1'b1; m_pdiv = int'(cfg_div); m_ready = 1'b0;
      end else if (m_pv && (m_st == 0 || wrp)) begin
        m_div = (m_pdiv == 0) ? 1 : m_pdiv;
        m_pv  = 1'b0;
        if (m_st == 0) m_ready = 1'b1;
        else           m_ready_at = m_edge + 1;
      end else if (m_ready_at == m_edge) begin
        m_ready = 1'b1;
      end
      if (strt) m_next = m_edge + m_div;
      if (step) begin
        m_addr = (m_addr + 1) % SIN;
        m_next = m_edge + m_div;
      end
      case (m_st)
        0:       if (enable) m_st = 1;
        1:       if (!enable) m_st = 2;
        default: if (enable) m_st = 1; else if (wrp) begin m_st = 0; m_addr = 0; end
      endcase
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_on) begin
      chk("sb_addr", 64'(pram_addr), 64'(m_addr));
      chk("sb_ctrl", 64'({cfg_ready, sample_valid, period_start, running}),
                     64'({m_ready, m_sv, m_ps, (m_st != 0)}));
      chk("sb_samples", 64'({sample_a, sample_b, sample_c}), 64'({m_sa, m_sb, m_sc}));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    enable = 1'b0; cfg_valid = 1'b0;
    #2 rst_n = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic set_div(input int d);
    int n = 0;
    cfg_div = DIV_W'(d); cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    chk("cfg_busy", 64'(cfg_ready), 64'(0));
    while (!cfg_ready && n < 10) begin @(negedge clk); n++; end
    chk("cfg_idle_apply", 64'(n), 64'(1));
  endtask

  task automatic wait_addr(input int a, input int budget, input string nm);
    int n = 0;
    while (int'(pram_addr) != a && n < budget) begin @(negedge clk); n++; end
    chk(nm, 64'(int'(pram_addr)), 64'(a));
  endtask

  typedef struct { int div; int exp_first; int exp_gap; } vec_t;
  vec_t tbl[5];

  initial begin
    int n, ps_n, sv_n, bad;
    tbl[0] = '{1, 2, 1};
    tbl[1] = '{4, 5, 4};
    tbl[2] = '{0, 2, 1};
    tbl[3] = '{2, 3, 2};
    tbl[4] = '{7, 8, 7};

    repeat (3) @(negedge clk);
    chk("rst_addr", 64'(pram_addr), 64'(0));
    chk("rst_ctrl", 64'({cfg_ready, sample_valid, period_start, running}), 64'(4'b1000));
    chk("rst_samples", 64'({sample_a, sample_b, sample_c}), 64'(0));
    #2 rst_n = 1'b1;
    chk_on = 1'b1;

    // Divider table: first step latency, step spacing, sample latency.
    for (int i = 0; i < 5; i++) begin
      do_reset();
      set_div(tbl[i].div);
      enable = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (pram_addr == '0 && n < 40);
      chk($sformatf("tbl%0d_first", i), 64'(n), 64'(tbl[i].exp_first));
      @(negedge clk);
      chk($sformatf("tbl%0d_sample", i), 64'({sample_valid, sample_a}), 64'({1'b1, lut(0, 1)}));
      n = 1;
      while (pram_addr == ADDR_W'(1) && n < 40) begin @(negedge clk); n++; end
      chk($sformatf("tbl%0d_gap", i), 64'(n), 64'(tbl[i].exp_gap));
    end

    // div=1 full periods, then wrap with enable low drains a whole extra period.
    do_reset();
    set_div(1);
    enable = 1'b1; ps_n = 0; sv_n = 0;
    for (int j = 0; j < 6005; j++) begin
      @(negedge clk);
      ps_n += int'(period_start);
      sv_n += int'(sample_valid);
    end
    chk("ps_per_period", 64'(ps_n), 64'(2));
    chk("sv_every_cycle", 64'(sv_n), 64'(6004));
    wait_addr(2999, 3100, "reach_2999");
    enable = 1'b0; n = 0;
    do begin @(negedge clk); n++; end while (running && n < 3100);
    chk("drain_full_period", 64'(n), 64'(3001));
    chk("drain_idle_addr", 64'(pram_addr), 64'(0));

    // Asynchronous reset in the middle of a period.
    enable = 1'b1;
    wait_addr(1234, 1300, "reach_1234");
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_addr", 64'(pram_addr), 64'(0));
    chk("async_rst_ctrl", 64'({cfg_ready, sample_valid, period_start, running}), 64'(4'b1000));
    chk("async_rst_samples", 64'({sample_a, sample_b, sample_c}), 64'(0));
    enable = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_hold", 64'({running, pram_addr}), 64'(0));

    // Mid-period divider change takes effect only at wrap.
    do_reset();
    set_div(4);
    enable = 1'b1;
    wait_addr(500, 2100, "reach_500");
    cfg_div = DIV_W'(2); cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    chk("mid_accept", 64'(cfg_ready), 64'(0));
    bad = 0; n = 0;
    while (pram_addr != '0 && n < 10100) begin
      if (cfg_ready) bad++;
      @(negedge clk); n++;
    end
    chk("ready_held_low", 64'(bad), 64'(0));
    chk("wrap_ps", 64'(period_start), 64'(1));
    chk("ready_at_wrap", 64'(cfg_ready), 64'(0));
    n = 0;
    do begin
      @(negedge clk); n++;
      if (n == 1) chk("ready_after_wrap", 64'(cfg_ready), 64'(1));
    end while (pram_addr == '0 && n < 20);
    chk("new_gap", 64'(n), 64'(2));

    // enable drop mid-period: finish the period, then stop.
    wait_addr(100, 300, "reach_100");
    enable = 1'b0; n = 0;
    while (running && n < 6100) begin @(negedge clk); n++; end
    chk("drained_idle", 64'({running, pram_addr}), 64'(0));
    sv_n = 0;
    for (int j = 0; j < 10; j++) begin @(negedge clk); sv_n += int'(sample_valid); end
    chk("drain_last_sample", 64'(sv_n), 64'(1));
    chk("idle_addr_hold", 64'(pram_addr), 64'(0));

    // Random enable and divider traffic, checked by the scoreboard.
    do_reset();
    enable = 1'b1;
    for (int j = 0; j < 3000; j++) begin
      @(negedge clk);
      if ($urandom_range(0, 39) == 0) enable = ~enable;
      cfg_valid = ($urandom_range(0, 7) == 0);
      cfg_div   = DIV_W'($urandom_range(0, 3));
    end
    enable = 1'b0; cfg_valid = 1'b0;
    repeat (2) @(negedge clk);

    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
